// File: rtl/rv32_div_seq.sv
// rv32_div_seq: sequential RV32M DIV/DIVU/REM/REMU unit, 1 quotient bit per cycle.
// Ports: clk, reset_n, start/op/operands in, flush/hold in; stall, valid, result out.
module rv32_div_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_in,
  input  logic [1:0]  op_in,
  input  logic [31:0] dividend_in,
  input  logic [31:0] divisor_in,
  input  logic        flush_in,
  input  logic        hold_in,
  output logic        stall_out,
  output logic        result_valid_out,
  output logic [31:0] result_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rem_op_q, rem_op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;

  logic        is_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic        div_zero, ovf;
  logic [32:0] shl, diff;
  logic [31:0] quo_res, rem_res;

  assign is_signed = ~op_in[0];
  assign a_neg     = is_signed & dividend_in[31];
  assign b_neg     = is_signed & divisor_in[31];
  assign a_abs     = a_neg ? (~dividend_in + 32'd1) : dividend_in;
  assign b_abs     = b_neg ? (~divisor_in + 32'd1) : divisor_in;
  assign div_zero  = (divisor_in == 32'd0);
  assign ovf       = is_signed
                   & (dividend_in == 32'h8000_0000)
                   & (divisor_in == 32'hFFFF_FFFF);

  // Dividend magnitude shifts out of quo_q MSB-first while
  // quotient bits shift in at the bottom. The partial
  // remainder is always below the divisor, so a negative
  // trial difference always shows up in bit 32.
  assign shl  = {rem_q, quo_q[31]};
  assign diff = shl - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_op_d = rem_op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    if (flush_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_in) begin
            rem_op_d = op_in[1];
            cnt_d    = 5'd0;
            if (div_zero) begin
              // Final values stored raw; sign fix disabled.
              quo_d   = 32'hFFFF_FFFF;
              rem_d   = dividend_in;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = DONE;
            end else if (ovf) begin
              quo_d   = 32'h8000_0000;
              rem_d   = 32'd0;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = DONE;
            end else begin
              quo_d   = a_abs;
              rem_d   = 32'd0;
              dvs_d   = b_abs;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = diff[32] ? shl[31:0] : diff[31:0];
          quo_d = {quo_q[30:0], ~diff[32]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (!hold_in) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      rem_op_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_op_q <= rem_op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
    end
  end

  assign quo_res = qneg_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_res = rneg_q ? (~rem_q + 32'd1) : rem_q;

  assign result_out = (state_q == DONE)
                    ? (rem_op_q ? rem_res : quo_res)
                    : 32'd0;

  assign result_valid_out = (state_q == DONE) & ~flush_in;

  // Gated by reset_n so the hazard unit sees no stall while
  // the unit is held in reset.
  assign stall_out = reset_n & ~flush_in
                   & (((state_q == IDLE) & start_in)
                     | (state_q == CALC));

endmodule

// File: tb/tb_rv32_div_seq.sv
// tb_rv32_div_seq: directed vector bench for rv32_div_seq.
// Table-driven ops plus flush, hold and async reset sequences.
module tb_rv32_div_seq;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk;
  logic        reset_n;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic        flush_in;
  logic        hold_in;
  logic        stall_out;
  logic        result_valid_out;
  logic [31:0] result_out;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[20];

  rv32_div_seq dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start_in         (start_in),
    .op_in            (op_in),
    .dividend_in      (dividend_in),
    .divisor_in       (divisor_in),
    .flush_in         (flush_in),
    .hold_in          (hold_in),
    .stall_out        (stall_out),
    .result_valid_out (result_valid_out),
    .result_out       (result_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the unit in IDLE.
  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_lat,
                        input string name);
    int lat;
    int stalls;
    op_in       = op;
    dividend_in = a;
    divisor_in  = b;
    start_in    = 1'b1;
    #1;
    stalls = stall_out ? 1 : 0;
    @(negedge clk);
    start_in    = 1'b0;
    dividend_in = 32'hDEAD_BEEF;
    divisor_in  = 32'h0000_0003;
    lat = 1;
    #1;
    while (!result_valid_out && lat < 40) begin
      if (stall_out) stalls++;
      @(negedge clk);
      #1;
      lat++;
    end
    chk({name, "_result"}, result_out, exp);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_stalls"}, stalls, exp_lat);
    chk({name, "_done_stall"}, {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    #1;
    chk({name, "_idle_valid"}, {31'd0, result_valid_out}, 32'd0);
  endtask

  initial begin
    int vcnt;
    int d;
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    start_in    = 1'b1;
    op_in       = OP_DIVU;
    dividend_in = 32'd100;
    divisor_in  = 32'd7;
    flush_in    = 1'b0;
    hold_in     = 1'b0;

    vecs[0]  = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7"};
    vecs[1]  = '{OP_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7"};
    vecs[2]  = '{OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_m7_2"};
    vecs[3]  = '{OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_m7_2"};
    vecs[4]  = '{OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 33, "rem_7_m2"};
    vecs[5]  = '{OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_5_0"};
    vecs[6]  = '{OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_5_0"};
    vecs[7]  = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf"};
    vecs[8]  = '{OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf"};
    vecs[9]  = '{OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, "divu_max_1"};
    vecs[10] = '{OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 33, "div_m100_m7"};
    vecs[11] = '{OP_REM, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, "rem_m100_m7"};
    vecs[12] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, "divu_big"};
    vecs[13] = '{OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "remu_big"};
    vecs[14] = '{OP_DIVU, 32'd7, 32'd100, 32'd0, 33, "divu_7_100"};
    vecs[15] = '{OP_REM, 32'd5, 32'd0, 32'd5, 1, "rem_5_0"};
    vecs[16] = '{OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1, "div_m5_0"};
    vecs[17] = '{OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, "rem_m5_0"};
    vecs[18] = '{OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33, "divu_max_max"};
    vecs[19] = '{OP_REMU, 32'h00BC614E, 32'd1000, 32'd678, 33, "remu_12345678"};
    vcnt = 20;

    // Reset state, with start_in asserted during reset.
    #12;
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_valid", {31'd0, result_valid_out}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    start_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back table vectors.
    for (int i = 0; i < vcnt; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, vecs[i].name);
    end

    // Flush mid-CALC.
    op_in       = OP_DIVU;
    dividend_in = 32'd100;
    divisor_in  = 32'd7;
    start_in    = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (9) @(negedge clk);
    flush_in = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_out}, 32'd0);
    chk("flush_valid", {31'd0, result_valid_out}, 32'd0);
    @(negedge clk);
    flush_in = 1'b0;
    #1;
    chk("post_flush_stall", {31'd0, stall_out}, 32'd0);
    d = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid_out) d++;
      @(negedge clk);
    end
    chk("post_flush_no_valid", d, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "after_flush");

    // Flush while IDLE with start: not accepted.
    op_in       = OP_DIVU;
    dividend_in = 32'd50;
    divisor_in  = 32'd5;
    start_in    = 1'b1;
    flush_in    = 1'b1;
    #1;
    chk("idle_flush_stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    start_in = 1'b0;
    flush_in = 1'b0;
    #1;
    chk("idle_flush_calc", {31'd0, stall_out}, 32'd0);

    // Hold in DONE; start_in and operands wiggle during CALC.
    @(negedge clk);
    op_in       = OP_DIVU;
    dividend_in = 32'd100;
    divisor_in  = 32'd7;
    start_in    = 1'b1;
    hold_in     = 1'b1;
    @(negedge clk);
    op_in       = OP_REM;
    dividend_in = 32'd999;
    divisor_in  = 32'd0;
    repeat (4) @(negedge clk);
    start_in = 1'b0;
    #1;
    d = 0;
    while (!result_valid_out && d < 40) begin
      @(negedge clk);
      #1;
      d++;
    end
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("hold_valid_%0d", j), {31'd0, result_valid_out}, 32'd1);
      chk($sformatf("hold_result_%0d", j), result_out, 32'd14);
      if (j == 4) hold_in = 1'b0;
      @(negedge clk);
      #1;
    end
    chk("hold_release", {31'd0, result_valid_out}, 32'd0);

    // Async reset mid-CALC.
    op_in       = OP_DIVU;
    dividend_in = 32'd100;
    divisor_in  = 32'd7;
    start_in    = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_stall", {31'd0, stall_out}, 32'd0);
    chk("async_rst_valid", {31'd0, result_valid_out}, 32'd0);
    chk("async_rst_result", result_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
